// File: rtl/ysyx_24090003_lsu_mc_pkg.sv
// Shared encodings for the multi-cycle LSU: access widths, FSM states and fault causes.
package ysyx_24090003_lsu_mc_pkg;

    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;
    localparam logic [1:0] LSU_D = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // Fault causes, reserved for a future mcause interface
    localparam logic [3:0] LSU_ERR_NONE     = 4'd0;
    localparam logic [3:0] LSU_ERR_MISALIGN = 4'd1;
    localparam logic [3:0] LSU_ERR_WIDTH    = 4'd2;
    localparam logic [3:0] LSU_ERR_BUS      = 4'd3;
    localparam logic [3:0] LSU_ERR_TIMEOUT  = 4'd4;

    // Access size minus one, used as the alignment mask
    function automatic logic [2:0] lsu_size_mask(input logic [1:0] width);
        case (width)
            LSU_B:   lsu_size_mask = 3'd0;
            LSU_H:   lsu_size_mask = 3'd1;
            LSU_W:   lsu_size_mask = 3'd3;
            default: lsu_size_mask = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24090003_lsu_align.sv
// Combinational lane logic: store strobe/data alignment, load extraction/extension, fault detection.
module ysyx_24090003_lsu_align
    import ysyx_24090003_lsu_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] i_off,
    input  logic [1:0]                  i_width,
    input  logic                        i_unsigned,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [DATA_W-1:0]           i_rdata,
    output logic [DATA_W/8-1:0]         o_wstrb_c,
    output logic [DATA_W-1:0]           o_wdata_c,
    output logic [DATA_W-1:0]           o_rdata_c,
    output logic                        o_fault_c
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    logic [2:0]        w_mask;
    logic [STRB_W-1:0] w_base;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_keep;
    logic              w_sign;

    assign w_mask    = lsu_size_mask(i_width);
    assign o_fault_c = (|(i_off & OFF_W'(w_mask))) || ((i_width == LSU_D) && (DATA_W == 32));
    assign o_wdata_c = i_wdata << {i_off, 3'b000};
    assign o_wstrb_c = w_base << i_off;
    assign w_shift   = i_rdata >> {i_off, 3'b000};

    always_comb begin
        w_base = '1;
        case (i_width)
            LSU_B:   w_base = STRB_W'(8'h01);
            LSU_H:   w_base = STRB_W'(8'h03);
            LSU_W:   w_base = STRB_W'(8'h0F);
            default: ;
        endcase
    end

    // Keep the access-sized low bits, then fill the rest with the sign bit for signed loads
    always_comb begin
        w_keep = '1;
        w_sign = w_shift[DATA_W-1];
        case (i_width)
            LSU_B: begin w_keep = DATA_W'(8'hFF);        w_sign = w_shift[7];  end
            LSU_H: begin w_keep = DATA_W'(16'hFFFF);     w_sign = w_shift[15]; end
            LSU_W: begin w_keep = DATA_W'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
            default: ;
        endcase
        o_rdata_c = (w_shift & w_keep) | ((w_sign && !i_unsigned) ? ~w_keep : '0);
    end

endmodule

// File: rtl/ysyx_24090003_lsu_mc.sv
// Multi-cycle load/store unit: one access at a time, lane-aligned bus request, timeout and fault reporting.
module ysyx_24090003_lsu_mc
    import ysyx_24090003_lsu_mc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic                i_req_we,
    input  logic [1:0]          i_req_width,
    input  logic                i_req_unsigned,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_we,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_rerr
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e        r_state;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_width;
    logic              r_unsigned;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;

    logic [OFF_W-1:0]  w_off;
    logic [1:0]        w_width;
    logic              w_unsigned;
    logic [STRB_W-1:0] w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_fault;

    // Align unit sees the incoming request in IDLE and the latched one afterwards
    assign w_off      = (r_state == S_IDLE) ? i_req_addr[OFF_W-1:0] : r_off;
    assign w_width    = (r_state == S_IDLE) ? i_req_width : r_width;
    assign w_unsigned = (r_state == S_IDLE) ? i_req_unsigned : r_unsigned;

    ysyx_24090003_lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_off      (w_off),
        .i_width    (w_width),
        .i_unsigned (w_unsigned),
        .i_wdata    (i_req_wdata),
        .i_rdata    (i_mem_rdata),
        .o_wstrb_c  (w_wstrb),
        .o_wdata_c  (w_wdata),
        .o_rdata_c  (w_rdata),
        .o_fault_c  (w_fault)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_off       <= '0;
            r_width     <= '0;
            r_unsigned  <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_req_ready <= 1'b1;
                    if (o_req_ready && i_req_valid) begin
                        o_req_ready <= 1'b0;
                        r_off       <= i_req_addr[OFF_W-1:0];
                        r_width     <= i_req_width;
                        r_unsigned  <= i_req_unsigned;
                        r_we        <= i_req_we;
                        if (w_fault) begin
                            r_state     <= S_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else begin
                            r_state     <= S_REQ;
                            o_mem_valid <= 1'b1;
                            o_mem_addr  <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            o_mem_we    <= i_req_we;
                            o_mem_wdata <= w_wdata;
                            o_mem_wstrb <= i_req_we ? w_wstrb : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        r_state     <= S_WAIT;
                        r_cnt       <= '0;
                        o_mem_valid <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_we    <= 1'b0;
                        o_mem_wdata <= '0;
                        o_mem_wstrb <= '0;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle takes priority
                    if (i_mem_rvalid) begin
                        r_state     <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= i_mem_rerr;
                        o_rsp_rdata <= (r_we || i_mem_rerr) ? '0 : w_rdata;
                    end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
                        r_state     <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        o_req_ready <= 1'b1;
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_lsu_mc.sv
// Randomized bench for the multi-cycle LSU against an arithmetic reference model (DATA_W=32, TIMEOUT=4).
module tb_ysyx_24090003_lsu_mc;
    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid, o_req_ready;
    logic [31:0] i_req_addr, i_req_wdata;
    logic        i_req_we, i_req_unsigned;
    logic [1:0]  i_req_width;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic        o_mem_valid, i_mem_ready, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_rvalid, i_mem_rerr;
    logic [31:0] i_mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;

    ysyx_24090003_lsu_mc #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_we(i_req_we),
        .i_req_width(i_req_width), .i_req_unsigned(i_req_unsigned),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .i_mem_rerr(i_mem_rerr)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One complete access; all expectations come from byte-level arithmetic on the request
    task automatic do_access(input logic [31:0] addr, input logic we, input logic [1:0] w,
                             input logic uns, input logic [31:0] wd, input int rdy_dly,
                             input int lat, input logic [31:0] raw, input logic rerr,
                             input int stall);
        int          nb, off, k, lat_exp;
        bit          fault;
        logic [63:0] v, keep;
        logic [7:0]  strb8;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_strb;
        logic        e_err;

        nb     = 1 << w;
        off    = int'(addr % 4);
        fault  = ((addr % nb) != 0) || (nb > 4);
        e_addr = addr & 32'hFFFF_FFFC;
        strb8  = 8'((16'd1 << nb) - 16'd1) << off;
        e_strb = we ? strb8[3:0] : 4'h0;
        v      = {32'd0, wd} << (8 * off);
        e_wd   = v[31:0];
        keep   = (64'd1 << (8 * nb)) - 64'd1;
        v      = ({32'd0, raw} >> (8 * off)) & keep;
        if (!uns && v[8*nb-1]) v = v | ~keep;
        lat_exp = (lat > TO) ? TO : lat;
        if (fault)         begin e_err = 1'b1; e_rd = 32'd0; end
        else if (lat > TO) begin e_err = 1'b1; e_rd = 32'd0; end
        else               begin e_err = rerr; e_rd = (we || rerr) ? 32'd0 : v[31:0]; end

        i_req_valid = 1'b1; i_req_addr = addr; i_req_we = we;
        i_req_width = w; i_req_unsigned = uns; i_req_wdata = wd;
        k = 0;
        while (!o_req_ready && k < 10) begin tick(); k++; end
        check("req_ready", 64'(o_req_ready), 64'd1);
        tick();
        t_acc = cyc;
        i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom;
        i_req_we = 1'($urandom); i_req_width = 2'($urandom); i_req_unsigned = 1'($urandom);
        check("req_ready_busy", 64'(o_req_ready), 64'd0);

        if (fault) begin
            check("mem_valid_fault", 64'(o_mem_valid), 64'd0);
        end else begin
            for (int c = 0; c <= rdy_dly; c++) begin
                check("mem_valid", 64'(o_mem_valid), 64'd1);
                check("mem_addr",  64'(o_mem_addr),  64'(e_addr));
                check("mem_we",    64'(o_mem_we),    64'(we));
                check("mem_wstrb", 64'(o_mem_wstrb), 64'(e_strb));
                if (we) check("mem_wdata", 64'(o_mem_wdata), 64'(e_wd));
                i_mem_ready  = (c == rdy_dly);
                i_mem_rvalid = 1'($urandom);
                i_mem_rdata  = $urandom;
                i_mem_rerr   = 1'($urandom);
                tick();
            end
            i_mem_ready = 1'b0;
            check("mem_valid_drop", 64'(o_mem_valid), 64'd0);
            k = 0;
            do begin
                k++;
                i_mem_rvalid = (k == lat);
                i_mem_rdata  = (k == lat) ? raw : $urandom;
                i_mem_rerr   = (k == lat) ? rerr : 1'($urandom);
                tick();
            end while (!o_rsp_valid && k < 40);
            i_mem_rvalid = 1'b0;
            check("rsp_latency", 64'(k), 64'(lat_exp));
        end

        for (int c = 0; c <= stall; c++) begin
            check("rsp_valid", 64'(o_rsp_valid), 64'd1);
            check("rsp_err",   64'(o_rsp_err),   64'(e_err));
            check("rsp_rdata", 64'(o_rsp_rdata), 64'(e_rd));
            check("req_ready_resp", 64'(o_req_ready), 64'd0);
            i_rsp_ready = (c == stall);
            i_req_valid = (c != stall) ? 1'($urandom) : 1'b0;
            tick();
        end
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b0;
        check("rsp_valid_drop", 64'(o_rsp_valid), 64'd0);
        check("req_ready_back", 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        int          t0, nb;
        logic [31:0] a;
        logic [1:0]  w;

        i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0;
        i_req_we = 1'b0; i_req_width = '0; i_req_unsigned = 1'b0; i_rsp_ready = 1'b0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_rerr = 1'b0;
        #1;
        check("rst_ctrl", 64'({o_req_ready, o_mem_valid, o_mem_we, o_rsp_valid, o_rsp_err}), 64'd0);
        check("rst_data", 64'(o_mem_addr | o_mem_wdata | o_rsp_rdata | 32'(o_mem_wstrb)), 64'd0);
        tick(); tick();
        i_rst_n = 1'b1;
        tick();

        do_access(32'h8000_0003, 1'b1, 2'b00, 1'b0, 32'h0000_00AB, 0, 1, 32'h0, 1'b0, 0);
        do_access(32'h8000_0002, 1'b0, 2'b01, 1'b0, 32'h0, 0, 1, 32'h8001_1234, 1'b0, 0);
        do_access(32'h8000_0002, 1'b0, 2'b01, 1'b1, 32'h0, 0, 1, 32'h8001_1234, 1'b0, 0);
        do_access(32'h8000_0001, 1'b0, 2'b10, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0, 0);
        do_access(32'h8000_0000, 1'b0, 2'b11, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0, 0);
        do_access(32'h8000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 5, 4, 32'hDEAD_BEEF, 1'b1, 1);
        do_access(32'h8000_0020, 1'b1, 2'b10, 1'b0, 32'h1234_5678, 0, 2, 32'h0, 1'b1, 0);
        do_access(32'h8000_0024, 1'b0, 2'b10, 1'b0, 32'h0, 0, 30, 32'hCAFE_F00D, 1'b0, 0);
        do_access(32'h8000_0024, 1'b0, 2'b10, 1'b0, 32'h0, 0, 4, 32'hCAFE_F00D, 1'b0, 0);

        do_access(32'h8000_0030, 1'b0, 2'b00, 1'b0, 32'h0, 0, 1, 32'h0000_0080, 1'b0, 0);
        t0 = t_acc;
        do_access(32'h8000_0031, 1'b0, 2'b00, 1'b1, 32'h0, 0, 1, 32'h0000_8000, 1'b0, 3);
        check("b2b_interval", 64'(t_acc - t0), 64'd4);
        do_access(32'h8000_0034, 1'b0, 2'b01, 1'b0, 32'h0, 0, 1, 32'h7FFF_0000, 1'b0, 3);

        // Reset while waiting for the bus response
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0040; i_req_we = 1'b0;
        i_req_width = 2'b10; i_req_unsigned = 1'b0;
        tick();
        i_req_valid = 1'b0; i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        tick();
        i_rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 64'({o_req_ready, o_mem_valid, o_mem_we, o_rsp_valid, o_rsp_err}), 64'd0);
        check("midrst_data", 64'(o_mem_addr | o_mem_wdata | o_rsp_rdata | 32'(o_mem_wstrb)), 64'd0);
        tick();
        i_rst_n = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
        tick();
        i_mem_rvalid = 1'b0;
        check("postrst_ready", 64'(o_req_ready), 64'd1);
        check("postrst_rsp",   64'(o_rsp_valid), 64'd0);
        check("postrst_mem",   64'(o_mem_valid), 64'd0);

        for (int n = 0; n < 200; n++) begin
            w  = 2'($urandom_range(0, 3));
            nb = 1 << w;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
            do_access(a, 1'($urandom), w, 1'($urandom), $urandom, $urandom_range(0, 3),
                      $urandom_range(1, 6), $urandom, ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
